// File: rtl/mat_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_acc_pkg
// Purpose  : Shared types and constants for the 2x2 matrix accelerator.
// Revision : 1.0 - initial release
// ============================================================================
package mat_acc_pkg;

    localparam int DATA_W = 8;
    localparam int N      = 2;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [N-1:0][N-1:0] mat_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mat_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_stream_loader_if
// Purpose  : Element input stream and result output stream of the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface mat_stream_loader_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/mat_c_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mat_c_serializer
// Purpose  : Captures result C and streams it out row-major, C11 flagged last.
// Revision : 1.0 - initial release
// ============================================================================
module mat_c_serializer #(
    parameter int DATA_W = 8,
    parameter int N      = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             capture,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] mat_C,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic                             drain_end
);

    logic [N-1:0][N-1:0][DATA_W-1:0] r_c;
    logic [1:0]                      r_out_cnt;
    logic                            r_valid;
    logic                            w_hs;

    assign w_hs      = r_valid && out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_c[r_out_cnt[1]][r_out_cnt[0]];
    assign out_last  = r_valid && (r_out_cnt == 2'd3);
    assign drain_end = w_hs && (r_out_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c       <= '0;
            r_out_cnt <= 2'd0;
            r_valid   <= 1'b0;
        end else if (capture) begin
            r_c       <= mat_C;
            r_out_cnt <= 2'd0;
            r_valid   <= 1'b1;
        end else if (w_hs) begin
            // Counter wraps 3 -> 0 on the last element, ready for the next result.
            r_out_cnt <= r_out_cnt + 2'd1;
            if (r_out_cnt == 2'd3) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mat_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : mat_stream_loader
// Purpose  : Loads A/B from a stream, starts the multiplier, streams C back.
//            Optional RUN watchdog: define MAT_STREAM_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mat_stream_loader #(
    parameter int DATA_W         = 8,
    parameter int N              = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    mat_stream_loader_if.slave               strm,
    output logic [N-1:0][N-1:0][DATA_W-1:0] mat_A,
    output logic [N-1:0][N-1:0][DATA_W-1:0] mat_B,
    output logic                             start,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] mat_C,
    input  logic                             done,
    output logic                             busy,
    output logic                             err
);
    import mat_acc_pkg::*;

    loader_state_e                   r_state;
    loader_state_e                   w_next;
    logic [2:0]                      r_in_cnt;
    logic [N-1:0][N-1:0][DATA_W-1:0] r_mat_a;
    logic [N-1:0][N-1:0][DATA_W-1:0] r_mat_b;
    logic                            w_in_hs;
    logic                            w_done_run;
    logic                            w_timeout;
    logic                            w_drain_end;

    assign w_in_hs        = (r_state == LOAD) && strm.in_valid;
    assign w_done_run     = (r_state == RUN) && done;
    assign strm.in_ready  = (r_state == LOAD);
    assign start          = (r_state == RUN);
    assign busy           = (r_state != LOAD);
    assign mat_A          = r_mat_a;
    assign mat_B          = r_mat_b;

`ifdef MAT_STREAM_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_wd_cnt;
    logic            r_err;

    // Counter equals the number of RUN cycles already elapsed; zero outside RUN.
    assign w_timeout = (r_state == RUN) && !done &&
                       (r_wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != RUN) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD: begin
                if (w_in_hs && (r_in_cnt == 3'd7)) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (done) begin
                    w_next = DRAIN;
                end else if (w_timeout) begin
                    w_next = LOAD;
                end
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_next = LOAD;
                end
            end
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LOAD;
            r_in_cnt <= 3'd0;
            r_mat_a  <= '0;
            r_mat_b  <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_hs) begin
                // Element 7 wraps the counter to 0, so a new load starts clean.
                r_in_cnt <= r_in_cnt + 3'd1;
                if (!r_in_cnt[2]) begin
                    r_mat_a[r_in_cnt[1]][r_in_cnt[0]] <= strm.in_data;
                end else begin
                    r_mat_b[r_in_cnt[1]][r_in_cnt[0]] <= strm.in_data;
                end
            end
        end
    end

    mat_c_serializer #(
        .DATA_W (DATA_W),
        .N      (N)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (w_done_run),
        .mat_C     (mat_C),
        .out_ready (strm.out_ready),
        .out_data  (strm.out_data),
        .out_valid (strm.out_valid),
        .out_last  (strm.out_last),
        .drain_end (w_drain_end)
    );

endmodule
`default_nettype wire

// File: tb/tb_mat_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_stream_loader
// Purpose  : Randomized and directed bench with a behavioural loader model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_stream_loader;

    localparam int TO_CYC = 16;
`ifdef MAT_STREAM_LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0][1:0][7:0]  mat_A, mat_B, mat_C;
    logic                  start, done, busy, err;

    always #5 clk = ~clk;

    mat_stream_loader_if #(.DATA_W(8)) strm ();

    mat_stream_loader #(
        .DATA_W         (8),
        .N              (2),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .strm  (strm),
        .mat_A (mat_A),
        .mat_B (mat_B),
        .start (start),
        .mat_C (mat_C),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- multiplier environment: done 3 cycles after start ----
    bit       force_done = 1'b0;
    bit       no_done    = 1'b0;
    logic [2:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    m_cnt <= 3'd0;
        else if (!start)               m_cnt <= 3'd0;
        else if (m_cnt != 3'd7)        m_cnt <= m_cnt + 3'd1;
    end

    assign done = force_done || (start && (m_cnt == 3'd3) && !no_done);

    always_comb begin
        mat_C = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                mat_C[r][c] = 8'((int'(mat_A[r][0]) * int'(mat_B[0][c])) +
                                 (int'(mat_A[r][1]) * int'(mat_B[1][c])));
    end

    // ---------------- out_ready driver: 0 = high, 1 = random, 2 = low -------
    int rdy_mode = 0;
    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0)      strm.out_ready = 1'b1;
        else if (rdy_mode == 1) strm.out_ready = 1'($urandom % 2);
        else                    strm.out_ready = 1'b0;
    end

    // ---------------- behavioural model + per-cycle compare -----------------
    int                   phase = 0;     // 0 loading, 1 computing, 2 draining
    logic [7:0]           elems[$];
    logic [1:0][1:0][7:0] ea, eb;
    logic [7:0]           expc[4];
    int                   oi = 0, wd = 0;
    bit                   exp_err = 1'b0;
    logic [8:0]           got[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_start",     32'(start),          0);
            chk("rst_busy",      32'(busy),           0);
            chk("rst_err",       32'(err),            0);
            chk("rst_out_valid", 32'(strm.out_valid), 0);
            chk("rst_out_last",  32'(strm.out_last),  0);
            chk("rst_mat_A",     32'(mat_A),          0);
            chk("rst_mat_B",     32'(mat_B),          0);
            phase = 0; oi = 0; wd = 0; exp_err = 1'b0;
            elems.delete();
        end else begin
            chk("in_ready",  32'(strm.in_ready),  32'(phase == 0));
            chk("busy",      32'(busy),           32'(phase != 0));
            chk("start",     32'(start),          32'(phase == 1));
            chk("out_valid", 32'(strm.out_valid), 32'(phase == 2));
            chk("err",       32'(err),            32'(exp_err));
            if (strm.out_valid && strm.out_ready)
                got.push_back({strm.out_last, strm.out_data});
            case (phase)
                0: begin
                    chk("out_last_idle", 32'(strm.out_last), 0);
                    if (strm.in_valid) begin
                        elems.push_back(strm.in_data);
                        if (elems.size() == 8) begin
                            for (int i = 0; i < 4; i++) begin
                                ea[i/2][i%2] = elems[i];
                                eb[i/2][i%2] = elems[i+4];
                            end
                            for (int i = 0; i < 4; i++)
                                expc[i] = 8'(int'(ea[i/2][0]) * int'(eb[0][i%2]) +
                                             int'(ea[i/2][1]) * int'(eb[1][i%2]));
                            elems.delete();
                            phase = 1; wd = 0;
                        end
                    end
                end
                1: begin
                    chk("run_mat_A", 32'(mat_A), 32'(ea));
                    chk("run_mat_B", 32'(mat_B), 32'(eb));
                    if (done) begin
                        phase = 2; oi = 0;
                    end else if (TO_EN && wd == TO_CYC - 1) begin
                        phase = 0; exp_err = 1'b1;
                    end else begin
                        wd++;
                    end
                end
                default: begin
                    chk("out_data", 32'(strm.out_data), 32'(expc[oi]));
                    chk("out_last", 32'(strm.out_last), 32'(oi == 3));
                    if (strm.out_ready) begin
                        oi++;
                        if (oi == 4) phase = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input logic [7:0] e[8], input int lo, input int hi, input bit rnd);
        for (int i = lo; i <= hi; i++) begin
            int  tries = 0;
            bit  acc   = 1'b0;
            strm.in_data = e[i];
            while (!acc) begin
                strm.in_valid = rnd ? 1'($urandom % 2) : 1'b1;
                @(negedge clk);
                acc = strm.in_valid && strm.in_ready;
                @(posedge clk); #1;
                tries++;
                if (tries > 200) begin
                    chk("send_timeout", 32'(tries), 0);
                    strm.in_valid = 1'b0;
                    return;
                end
            end
        end
        strm.in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int k = 0; k < 300 && got.size() < n; k++) @(negedge clk);
        @(posedge clk); #1;
        chk("got_count", 32'(got.size()), 32'(n));
    endtask

    task automatic chk_got(input string nm, input logic [7:0] ex[4]);
        for (int i = 0; i < 4; i++) begin
            logic [8:0] g;
            g = (i < got.size()) ? got[i] : 9'h1FF;
            chk(nm, 32'(g), 32'({(i == 3), ex[i]}));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [7:0] v24[8]  = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd4, 8'd4, 8'd4, 8'd4};
    logic [7:0] v18[8]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [7:0] v3i[8]  = '{8'd3, 8'd0, 8'd0, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] e16[4]  = '{8'd16, 8'd16, 8'd16, 8'd16};
    logic [7:0] e19[4]  = '{8'd19, 8'd22, 8'd43, 8'd50};
    logic [7:0] e3[4]   = '{8'd3, 8'd6, 8'd9, 8'd12};
    logic [7:0] vr[8];

    initial begin
        strm.in_valid = 1'b0;
        strm.in_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(strm.in_ready), 1);
        @(posedge clk); #1;

        // Test 1: back-to-back input, A all 2, B all 4
        got.delete();
        send(v24, 0, 7, 1'b0);
        wait_got(4);
        chk_got("t1_out", e16);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 0);
        @(posedge clk); #1;

        // Test 2: random in_valid gaps
        got.delete();
        send(v18, 0, 7, 1'b1);
        wait_got(4);
        chk_got("t2_out", e19);

        // Test 3: output stalled for 5 cycles
        got.delete();
        rdy_mode = 2;
        send(v18, 0, 7, 1'b0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (strm.out_valid) begin seen = 1'b1; break; end
            end
            chk("t3_drain_seen", 32'(seen), 1);
            for (int j = 0; j < 5; j++) begin
                if (j > 0) @(negedge clk);
                chk("t3_stall_data",  32'(strm.out_data),  19);
                chk("t3_stall_valid", 32'(strm.out_valid), 1);
            end
            @(posedge clk); #1;
            rdy_mode = 0;
        end
        wait_got(4);
        chk_got("t3_out", e19);

        // Test 4: reset after 5 elements, then full reload
        got.delete();
        send(v18, 0, 4, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_mat_A", 32'(mat_A), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(v24, 0, 7, 1'b0);
        wait_got(4);
        chk_got("t4_out", e16);

        // Test 5: done forced during LOAD must be ignored
        got.delete();
        force_done = 1'b1;
        send(v3i, 0, 6, 1'b0);
        @(negedge clk);
        chk("t5_start_in_load", 32'(start), 0);
        @(posedge clk); #1;
        force_done = 1'b0;
        send(v3i, 7, 7, 1'b0);
        wait_got(4);
        chk_got("t5_out", e3);

        // Randomized data, valid gaps and backpressure
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) begin
            got.delete();
            for (int i = 0; i < 8; i++) vr[i] = 8'($urandom_range(0, 255));
            send(vr, 0, 7, 1'b1);
            wait_got(4);
        end
        rdy_mode = 0;

`ifdef MAT_STREAM_LOADER_TIMEOUT_EN
        // Test 6: multiplier never answers
        got.delete();
        no_done = 1'b1;
        send(v18, 0, 7, 1'b0);
        repeat (TO_CYC + 6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_err",      32'(err),            1);
        chk("t6_start",    32'(start),          0);
        chk("t6_in_ready", 32'(strm.in_ready),  1);
        chk("t6_no_out",   32'(got.size()),     0);
        @(posedge clk); #1;
        no_done = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
